// File: rtl/flag_stack_unit.sv
// rtl/flag_stack_unit.sv - ALU flag register with save/restore stack and condition evaluator.
// Flag bits: C = [0], Z = [1], V = [2], N = [3].
module flag_stack_unit #(
  parameter int DEPTH      = 4,
  parameter int OVERWRITE  = 0,
  parameter int REG_STATUS = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ld,
  input  logic [3:0]                 ld_mask,
  input  logic [3:0]                 flags_in,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       err_clr,
  input  logic [3:0]                 cond,
  output logic                       status,
  output logic [3:0]                 flags_out,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       full,
  output logic                       empty,
  output logic                       ovf_err,
  output logic                       unf_err
);

  localparam int DW = $clog2(DEPTH + 1);
  // Array sized to the full index range so depth can address it directly.
  localparam int SLOTS = 1 << DW;
  localparam logic [DW-1:0] DMAX = DW'(DEPTH);
  localparam bit OVW = (OVERWRITE != 0);

  logic [3:0]    stack [SLOTS];
  logic [DW-1:0] top_idx;
  logic          do_push, do_pop;
  logic          push_ok, push_ovw, push_ovf;
  logic          pop_ok, pop_unf;
  logic          cond_res;
  logic          c_f, z_f, v_f, n_f;

  assign full    = (depth == DMAX);
  assign empty   = (depth == '0);
  assign top_idx = depth - DW'(1);

  // Simultaneous push and pop cancel out entirely.
  assign do_push  = push & ~pop;
  assign do_pop   = pop & ~push;
  assign push_ok  = do_push & ~full;
  assign push_ovw = do_push & full & OVW;
  assign push_ovf = do_push & full & ~OVW;
  assign pop_ok   = do_pop & ~empty;
  assign pop_unf  = do_pop & empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      flags_out <= 4'b0000;
      depth     <= '0;
      ovf_err   <= 1'b0;
      unf_err   <= 1'b0;
    end else begin
      if (pop_ok) begin
        flags_out <= stack[top_idx];
        depth     <= depth - DW'(1);
      end else begin
        if (ld) flags_out <= (flags_out & ~ld_mask) | (flags_in & ld_mask);
        if (push_ok) depth <= depth + DW'(1);
      end
      ovf_err <= push_ovf | (ovf_err & ~err_clr);
      unf_err <= pop_unf | (unf_err & ~err_clr);
    end
  end

  // Stack contents are not reset; they are only observable after a push.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (push_ok) begin
        stack[depth] <= flags_out;
      end else if (push_ovw) begin
        for (int i = 0; i < DEPTH - 1; i++) begin
          stack[DW'(i)] <= stack[DW'(i + 1)];
        end
        stack[DMAX - DW'(1)] <= flags_out;
      end
    end
  end

  assign c_f = flags_out[0];
  assign z_f = flags_out[1];
  assign v_f = flags_out[2];
  assign n_f = flags_out[3];

  always_comb begin
    cond_res = 1'b0;
    case (cond)
      4'h0: cond_res = 1'b0;
      4'h1: cond_res = 1'b1;
      4'h2: cond_res = z_f;
      4'h3: cond_res = ~z_f;
      4'h4: cond_res = c_f;
      4'h5: cond_res = ~c_f;
      4'h6: cond_res = v_f;
      4'h7: cond_res = ~v_f;
      4'h8: cond_res = n_f;
      4'h9: cond_res = ~n_f;
      4'hA: cond_res = ~(n_f ^ v_f);
      4'hB: cond_res = n_f ^ v_f;
      4'hC: cond_res = ~z_f & ~(n_f ^ v_f);
      4'hD: cond_res = z_f | (n_f ^ v_f);
      4'hE: cond_res = c_f & ~z_f;
      4'hF: cond_res = ~c_f | z_f;
      default: cond_res = 1'b0;
    endcase
  end

  generate
    if (REG_STATUS != 0) begin : g_reg_status
      logic status_q;
      always_ff @(posedge clk) begin
        if (rst) status_q <= 1'b0;
        else     status_q <= cond_res;
      end
      assign status = status_q;
    end else begin : g_comb_status
      assign status = cond_res;
    end
  endgenerate

endmodule

// File: tb/tb_flag_stack_unit.sv
// tb/tb_flag_stack_unit.sv - bench for flag_stack_unit across three parameter sets.
module tb_flag_stack_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, ld, push, pop, err_clr;
  logic [3:0] ld_mask, flags_in, cond;

  logic       st0, st1, st2, fu0, fu1, fu2, em0, em1, em2;
  logic       ov0, ov1, ov2, un0, un1, un2;
  logic [3:0] fo0, fo1, fo2;
  logic [2:0] dp0, dp1;
  logic [0:0] dp2;

  flag_stack_unit #(.DEPTH(4), .OVERWRITE(0), .REG_STATUS(0)) u_base (
    .clk(clk), .rst(rst), .ld(ld), .ld_mask(ld_mask), .flags_in(flags_in),
    .push(push), .pop(pop), .err_clr(err_clr), .cond(cond), .status(st0),
    .flags_out(fo0), .depth(dp0), .full(fu0), .empty(em0), .ovf_err(ov0), .unf_err(un0));

  flag_stack_unit #(.DEPTH(4), .OVERWRITE(1), .REG_STATUS(1)) u_ovw (
    .clk(clk), .rst(rst), .ld(ld), .ld_mask(ld_mask), .flags_in(flags_in),
    .push(push), .pop(pop), .err_clr(err_clr), .cond(cond), .status(st1),
    .flags_out(fo1), .depth(dp1), .full(fu1), .empty(em1), .ovf_err(ov1), .unf_err(un1));

  flag_stack_unit #(.DEPTH(1), .OVERWRITE(0), .REG_STATUS(0)) u_one (
    .clk(clk), .rst(rst), .ld(ld), .ld_mask(ld_mask), .flags_in(flags_in),
    .push(push), .pop(pop), .err_clr(err_clr), .cond(cond), .status(st2),
    .flags_out(fo2), .depth(dp2), .full(fu2), .empty(em2), .ovf_err(ov2), .unf_err(un2));

  logic [3:0] d_flags [3];
  int         d_dep   [3];
  logic       d_full [3], d_empty [3], d_ovf [3], d_unf [3], d_stat [3];

  assign d_flags[0] = fo0;  assign d_flags[1] = fo1;  assign d_flags[2] = fo2;
  assign d_dep[0] = int'(dp0); assign d_dep[1] = int'(dp1); assign d_dep[2] = int'(dp2);
  assign d_full[0] = fu0;   assign d_full[1] = fu1;   assign d_full[2] = fu2;
  assign d_empty[0] = em0;  assign d_empty[1] = em1;  assign d_empty[2] = em2;
  assign d_ovf[0] = ov0;    assign d_ovf[1] = ov1;    assign d_ovf[2] = ov2;
  assign d_unf[0] = un0;    assign d_unf[1] = un1;    assign d_unf[2] = un2;
  assign d_stat[0] = st0;   assign d_stat[1] = st1;   assign d_stat[2] = st2;

  localparam int CD [3] = '{4, 4, 1};
  localparam bit CO [3] = '{1'b0, 1'b1, 1'b0};
  localparam bit CR [3] = '{1'b0, 1'b1, 1'b0};

  // Reference model: a saved-flags list per configuration, oldest first.
  logic [3:0] mfl [3];
  logic [3:0] mstk [3][16];
  int         mdep [3];
  logic       movf [3], munf [3], msreg [3];

  int nvec = 0;
  int nerr = 0;

  function automatic logic cond_fn(input logic [3:0] f, input logic [3:0] c);
    logic cf, zf, vf, nf;
    cf = f[0]; zf = f[1]; vf = f[2]; nf = f[3];
    case (c)
      4'h0: return 1'b0;
      4'h1: return 1'b1;
      4'h2: return zf;
      4'h3: return !zf;
      4'h4: return cf;
      4'h5: return !cf;
      4'h6: return vf;
      4'h7: return !vf;
      4'h8: return nf;
      4'h9: return !nf;
      4'hA: return nf == vf;
      4'hB: return nf != vf;
      4'hC: return !zf && (nf == vf);
      4'hD: return zf || (nf != vf);
      4'hE: return cf && !zf;
      default: return !cf || zf;
    endcase
  endfunction

  function automatic logic mstat(input int k);
    return CR[k] ? msreg[k] : cond_fn(mfl[k], cond);
  endfunction

  task automatic model_step(input int k);
    logic [3:0] old;
    logic popped, set_o, set_u;
    old = mfl[k]; popped = 1'b0; set_o = 1'b0; set_u = 1'b0;
    if (rst) begin
      mfl[k] = 4'h0; mdep[k] = 0; movf[k] = 1'b0; munf[k] = 1'b0; msreg[k] = 1'b0;
    end else begin
      msreg[k] = cond_fn(old, cond);
      if (push && !pop) begin
        if (mdep[k] < CD[k]) begin
          mstk[k][mdep[k]] = old;
          mdep[k] = mdep[k] + 1;
        end else if (CO[k]) begin
          for (int i = 0; i < CD[k] - 1; i++) mstk[k][i] = mstk[k][i+1];
          mstk[k][CD[k]-1] = old;
        end else begin
          set_o = 1'b1;
        end
      end else if (pop && !push) begin
        if (mdep[k] > 0) begin
          mdep[k] = mdep[k] - 1;
          mfl[k] = mstk[k][mdep[k]];
          popped = 1'b1;
        end else begin
          set_u = 1'b1;
        end
      end
      if (ld && !popped) mfl[k] = (old & ~ld_mask) | (flags_in & ld_mask);
      movf[k] = set_o || (movf[k] && !err_clr);
      munf[k] = set_u || (munf[k] && !err_clr);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_step(k);
    #1;
  endtask

  task automatic apply(input logic l, input logic [3:0] m, input logic [3:0] fi,
                       input logic pu, input logic po, input logic ec, input logic [3:0] c);
    ld = l; ld_mask = m; flags_in = fi; push = pu; pop = po; err_clr = ec; cond = c;
    cycle();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    apply(0, 4'h0, 4'h0, 0, 0, 0, 4'h0);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    ld = 1; ld_mask = 4'hF; flags_in = 4'hF; push = 1; pop = 0; err_clr = 0; cond = 4'h1;
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      nvec++;
      if (d_flags[k] !== 4'h0 || d_dep[k] !== 0 || d_empty[k] !== 1'b1 || d_full[k] !== 1'b0 ||
          d_ovf[k] !== 1'b0 || d_unf[k] !== 1'b0) begin
        nerr++;
        $display("FAIL reset k=%0d: flags=%h depth=%0d empty=%b full=%b ovf=%b unf=%b (want 0,0,1,0,0,0)",
                 k, d_flags[k], d_dep[k], d_empty[k], d_full[k], d_ovf[k], d_unf[k]);
      end
    end
    nvec++;
    if (d_stat[1] !== 1'b0) begin
      nerr++;
      $display("FAIL reset_status: got %b want 0", d_stat[1]);
    end
  endtask

  task automatic test_load_mask();
    do_reset();
    apply(1, 4'b1010, 4'b1111, 0, 0, 0, 4'h2);
    nvec++;
    if (d_flags[0] !== 4'b1010) begin
      nerr++;
      $display("FAIL load_mask: flags got %b want 1010", d_flags[0]);
    end
    nvec++;
    if (d_stat[0] !== 1'b1) begin
      nerr++;
      $display("FAIL load_mask_status: got %b want 1", d_stat[0]);
    end
  endtask

  task automatic test_push_pop();
    do_reset();
    apply(1, 4'hF, 4'b0110, 0, 0, 0, 4'h0);
    apply(0, 4'h0, 4'h0, 1, 0, 0, 4'h0);
    nvec++;
    if (d_dep[0] !== 1) begin
      nerr++;
      $display("FAIL push_depth: got %0d want 1", d_dep[0]);
    end
    apply(1, 4'hF, 4'b0001, 0, 0, 0, 4'h0);
    apply(0, 4'h0, 4'h0, 0, 1, 0, 4'h0);
    nvec++;
    if (d_flags[0] !== 4'b0110 || d_dep[0] !== 0) begin
      nerr++;
      $display("FAIL pop_restore: flags=%b depth=%0d want 0110,0", d_flags[0], d_dep[0]);
    end
  endtask

  task automatic test_overflow();
    logic [3:0] e0 [4] = '{4'd4, 4'd3, 4'd2, 4'd1};
    logic [3:0] e1 [4] = '{4'd5, 4'd4, 4'd3, 4'd2};
    do_reset();
    for (int v = 1; v <= 5; v++) begin
      apply(1, 4'hF, 4'(v), 0, 0, 0, 4'h0);
      apply(0, 4'h0, 4'h0, 1, 0, 0, 4'h0);
    end
    nvec++;
    if (d_dep[0] !== 4 || d_full[0] !== 1'b1 || d_ovf[0] !== 1'b1) begin
      nerr++;
      $display("FAIL ovf_reject: depth=%0d full=%b ovf=%b want 4,1,1", d_dep[0], d_full[0], d_ovf[0]);
    end
    nvec++;
    if (d_dep[1] !== 4 || d_full[1] !== 1'b1 || d_ovf[1] !== 1'b0) begin
      nerr++;
      $display("FAIL ovf_overwrite: depth=%0d full=%b ovf=%b want 4,1,0", d_dep[1], d_full[1], d_ovf[1]);
    end
    nvec++;
    if (d_dep[2] !== 1 || d_full[2] !== 1'b1 || d_ovf[2] !== 1'b1) begin
      nerr++;
      $display("FAIL ovf_depth1: depth=%0d full=%b ovf=%b want 1,1,1", d_dep[2], d_full[2], d_ovf[2]);
    end
    for (int i = 0; i < 4; i++) begin
      apply(0, 4'h0, 4'h0, 0, 1, 0, 4'h0);
      nvec++;
      if (d_flags[0] !== e0[i] || d_flags[1] !== e1[i]) begin
        nerr++;
        $display("FAIL lifo_pop%0d: reject=%0d overwrite=%0d want %0d,%0d",
                 i, d_flags[0], d_flags[1], e0[i], e1[i]);
      end
      nvec++;
      if (d_flags[2] !== mfl[2] || d_unf[2] !== munf[2]) begin
        nerr++;
        $display("FAIL depth1_pop%0d: flags=%0d unf=%b want %0d,%b", i, d_flags[2], d_unf[2], mfl[2], munf[2]);
      end
    end
    nvec++;
    if (d_empty[0] !== 1'b1 || d_empty[1] !== 1'b1 || d_unf[0] !== 1'b0) begin
      nerr++;
      $display("FAIL drained: empty=%b,%b unf=%b want 1,1,0", d_empty[0], d_empty[1], d_unf[0]);
    end
  endtask

  task automatic test_underflow();
    do_reset();
    apply(1, 4'hF, 4'b0100, 0, 1, 0, 4'h0);
    for (int k = 0; k < 3; k++) begin
      nvec++;
      if (d_flags[k] !== 4'b0100 || d_unf[k] !== 1'b1 || d_dep[k] !== 0) begin
        nerr++;
        $display("FAIL underflow k=%0d: flags=%b unf=%b depth=%0d want 0100,1,0", k, d_flags[k], d_unf[k], d_dep[k]);
      end
    end
    apply(0, 4'h0, 4'h0, 0, 1, 1, 4'h0);
    nvec++;
    if (d_unf[0] !== 1'b1) begin
      nerr++;
      $display("FAIL set_beats_clr: unf=%b want 1", d_unf[0]);
    end
    apply(0, 4'h0, 4'h0, 0, 0, 1, 4'h0);
    nvec++;
    if (d_unf[0] !== 1'b0) begin
      nerr++;
      $display("FAIL err_clr: unf=%b want 0", d_unf[0]);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    apply(1, 4'hF, 4'h3, 0, 0, 0, 4'h0);
    apply(0, 4'h0, 4'h0, 1, 0, 0, 4'h0);
    apply(1, 4'hF, 4'h9, 1, 1, 0, 4'h0);
    nvec++;
    if (d_flags[0] !== 4'h9 || d_dep[0] !== 1 || d_ovf[0] !== 1'b0 || d_unf[0] !== 1'b0) begin
      nerr++;
      $display("FAIL push_and_pop: flags=%h depth=%0d ovf=%b unf=%b want 9,1,0,0",
               d_flags[0], d_dep[0], d_ovf[0], d_unf[0]);
    end
    apply(0, 4'h0, 4'h0, 0, 1, 0, 4'h0);
    nvec++;
    if (d_flags[0] !== 4'h3) begin
      nerr++;
      $display("FAIL push_and_pop_restore: flags=%h want 3", d_flags[0]);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 3; i++) apply(1, 4'hF, 4'(i + 7), 1, 0, 0, 4'h0);
    rst = 1'b1;
    apply(0, 4'h0, 4'h0, 0, 0, 0, 4'h0);
    rst = 1'b0;
    apply(0, 4'h0, 4'h0, 0, 1, 0, 4'h0);
    for (int k = 0; k < 3; k++) begin
      nvec++;
      if (d_unf[k] !== 1'b1 || d_dep[k] !== 0 || d_flags[k] !== 4'h0) begin
        nerr++;
        $display("FAIL reset_mid k=%0d: unf=%b depth=%0d flags=%h want 1,0,0", k, d_unf[k], d_dep[k], d_flags[k]);
      end
    end
  endtask

  task automatic test_cond_sweep();
    do_reset();
    for (int f = 0; f < 16; f++) begin
      for (int c = 0; c < 16; c++) begin
        apply(1, 4'hF, 4'(f), 0, 0, 0, 4'(c));
        nvec++;
        if (d_stat[1] !== msreg[1]) begin
          nerr++;
          $display("FAIL cond_delay f=%0d c=%0d: got %b want %b", f, c, d_stat[1], msreg[1]);
        end
        apply(0, 4'h0, 4'h0, 0, 0, 0, 4'(c));
        nvec++;
        if (d_stat[0] !== cond_fn(4'(f), 4'(c)) || d_stat[1] !== cond_fn(4'(f), 4'(c))) begin
          nerr++;
          $display("FAIL cond f=%0d c=%0d: comb=%b reg=%b want %b", f, c, d_stat[0], d_stat[1],
                   cond_fn(4'(f), 4'(c)));
        end
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 800; n++) begin
      rst = ($urandom_range(0, 49) == 0);
      apply($urandom_range(0, 1) == 1, 4'($urandom), 4'($urandom),
            $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 7) == 0, 4'($urandom));
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
        nvec++;
        if (d_flags[k] !== mfl[k] || d_dep[k] !== mdep[k] || d_full[k] !== (mdep[k] == CD[k]) ||
            d_empty[k] !== (mdep[k] == 0) || d_ovf[k] !== movf[k] || d_unf[k] !== munf[k] ||
            d_stat[k] !== mstat(k)) begin
          nerr++;
          $display("FAIL random n=%0d k=%0d: got f=%h d=%0d fu=%b em=%b o=%b u=%b s=%b want f=%h d=%0d o=%b u=%b s=%b",
                   n, k, d_flags[k], d_dep[k], d_full[k], d_empty[k], d_ovf[k], d_unf[k], d_stat[k],
                   mfl[k], mdep[k], movf[k], munf[k], mstat(k));
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; ld = 0; ld_mask = 0; flags_in = 0; push = 0; pop = 0; err_clr = 0; cond = 0;
    for (int k = 0; k < 3; k++) begin
      mfl[k] = 4'h0; mdep[k] = 0; movf[k] = 1'b0; munf[k] = 1'b0; msreg[k] = 1'b0;
    end
    test_reset();
    test_load_mask();
    test_push_pop();
    test_overflow();
    test_underflow();
    test_back_to_back();
    test_reset_mid();
    test_cond_sweep();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
